// File: rtl/mioc_inv1_nmos.sv
// MIOC NMOS single-input inverter cell with a clocked observation wrapper.
// Optional toggle statistics are enabled by defining MIOC_INV1_STATS_EN.
module mioc_inv1_nmos #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1,
    output logic             z,
    output logic             z_q,
    output logic             in_unk,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt
);

    logic z_unk;
    logic z_q_next;

    // An undriven or unknown gate terminal propagates as X through ~in1.
    assign z = ~in1;

    // An unknown sample must not disturb the held output or the statistics.
    assign z_unk    = $isunknown(z);
    assign z_q_next = z_unk ? z_q : z;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q    <= 1'b1;
            in_unk <= 1'b0;
        end else begin
            z_q    <= z_q_next;
            in_unk <= z_unk;
        end
    end

`ifdef MIOC_INV1_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic rise_evt;
    logic fall_evt;

    assign rise_evt = ~z_q & z_q_next;
    assign fall_evt = z_q & ~z_q_next;

    // Counters saturate so long characterisation runs never report a wrapped count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            if (rise_evt && (rise_cnt != CNT_MAX)) begin
                rise_cnt <= rise_cnt + CNT_ONE;
            end
            if (fall_evt && (fall_cnt != CNT_MAX)) begin
                fall_cnt <= fall_cnt + CNT_ONE;
            end
        end
    end
`else
    assign rise_cnt = '0;
    assign fall_cnt = '0;
`endif

endmodule

// File: tb/tb_mioc_inv1_nmos.sv
// Self-checking bench for mioc_inv1_nmos: directed steps with a scoreboard of
// expected registered outputs, valid for both the stats and default builds.
module tb_mioc_inv1_nmos;

    localparam int CNT_W = 4;
`ifdef MIOC_INV1_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct {
        logic             zq;
        logic             unk;
        logic [CNT_W-1:0] rise;
        logic [CNT_W-1:0] fall;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in1;
    logic             z;
    logic             z_q;
    logic             in_unk;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;

    exp_t sb[$];

    // Reference model state
    logic             m_zq;
    logic             m_unk;
    logic [CNT_W-1:0] m_rise;
    logic [CNT_W-1:0] m_fall;

    int n_checks;
    int n_fails;

    mioc_inv1_nmos #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .z        (z),
        .z_q      (z_q),
        .in_unk   (in_unk),
        .rise_cnt (rise_cnt),
        .fall_cnt (fall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_zq   = 1'b1;
        m_unk  = 1'b0;
        m_rise = '0;
        m_fall = '0;
        sb.delete();
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, "_zq"},   {31'd0, z_q},    {31'd0, e.zq});
        check({tag, "_unk"},  {31'd0, in_unk}, {31'd0, e.unk});
        check({tag, "_rise"}, 32'(rise_cnt),   32'(e.rise));
        check({tag, "_fall"}, 32'(fall_cnt),   32'(e.fall));
    endtask

    // Drive one value between edges, check z immediately, check registers after the edge.
    task automatic step(input logic v, input string tag);
        exp_t e;
        logic exp_z;
        logic nz;
        @(negedge clk);
        in1 = v;
        #1;
        exp_z = $isunknown(v) ? 1'bx : ~v;
        check({tag, "_z"}, {31'd0, z}, {31'd0, exp_z});
        if ($isunknown(v)) begin
            m_unk = 1'b1;
        end else begin
            nz    = ~v;
            m_unk = 1'b0;
            if (STATS) begin
                if (!m_zq && nz && (m_rise != CNT_MAX)) m_rise = m_rise + 1'b1;
                if (m_zq && !nz && (m_fall != CNT_MAX)) m_fall = m_fall + 1'b1;
            end
            m_zq = nz;
        end
        e.zq = m_zq; e.unk = m_unk; e.rise = m_rise; e.fall = m_fall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_regs(tag, e);
        end
    endtask

    // Assert reset between edges and verify the registers clear without a clock.
    task automatic mid_reset(input string tag);
        exp_t e;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        e.zq = m_zq; e.unk = m_unk; e.rise = m_rise; e.fall = m_fall;
        check_regs(tag, e);
        @(negedge clk);
        in1 = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic probe;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        in1 = 1'b0;
        model_reset();

        // Reset state, checked before any clock edge
        #2;
        e.zq = 1'b1; e.unk = 1'b0; e.rise = '0; e.fall = '0;
        check_regs("por", e);
        check("por_z", {31'd0, z}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Pattern file: in1 0,1,0,1 with logged in1 - z
        for (int i = 0; i < 4; i++) begin
            step(i[0], "pattern");
            $display("%b - %b", in1, z);
        end

        // Hold 0 for five clocks after reset
        mid_reset("rst_a");
        for (int i = 0; i < 5; i++) step(1'b0, "hold0");

        // Toggle every clock for 8 clocks starting at 1
        mid_reset("rst_b");
        for (int i = 0; i < 8; i++) step(~i[0], "toggle");
        check("toggle_rise_total", 32'(rise_cnt), STATS ? 32'd4 : 32'd0);
        check("toggle_fall_total", 32'(fall_cnt), STATS ? 32'd4 : 32'd0);

        // Glitch between edges: z follows it, registers do not
        @(negedge clk);
        in1 = 1'b1;
        #1;
        check("glitch_z_hi", {31'd0, z}, 32'd0);
        in1 = 1'b0;
        #1;
        check("glitch_z_lo", {31'd0, z}, 32'd1);
        step(1'b0, "glitch");

        // Unknown input, only meaningful on a four-state simulator
        probe = 1'bx;
        if ($isunknown(probe)) begin
            step(1'b1, "pre_x");
            step(1'bx, "x_in");
            step(1'b0, "x_clear");
        end

        // Saturation: 20 rising edges with CNT_W=4
        mid_reset("rst_c");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "sat_hi");
            step(1'b0, "sat_lo");
        end
        check("sat_rise_total", 32'(rise_cnt), STATS ? 32'd15 : 32'd0);
        check("sat_fall_total", 32'(fall_cnt), STATS ? 32'd15 : 32'd0);

        // Reset between edges, then counting resumes on the next edge
        mid_reset("rst_mid");
        step(1'b0, "resume_same");
        step(1'b1, "resume_fall");
        step(1'b0, "resume_rise");

        if (sb.size() != 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no end expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
